// File: rtl/interrupt_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// interrupt_arbiter : rotating-priority, nested interrupt arbiter (8259-style)
// Revision 1.0
// ---------------------------------------------------------------------------
module interrupt_arbiter #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               autoRotateMode,
  input  logic               inta,
  input  logic               eoi,
  input  logic               specificEoi,
  input  logic [ID_W-1:0]    eoiLevel,
  input  logic               setPriority,
  input  logic [ID_W-1:0]    priorityLevel,
  output logic               intReq,
  output logic [ID_W-1:0]    vector,
  output logic [NUM_IRQ-1:0] isr,
  output logic [ID_W-1:0]    lowestPriority
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t             state_q;
  logic               intReq_q;
  logic [ID_W-1:0]    vector_q;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [ID_W-1:0]    low_q, low_d;

  logic [NUM_IRQ-1:0] cand;
  logic [ID_W-1:0]    scan_idx;
  logic               win_valid, top_valid, elig;
  logic [ID_W-1:0]    win_id, top_id, win_rank, top_rank;
  logic               clr_valid;
  logic [ID_W-1:0]    clr_id;
  logic [NUM_IRQ-1:0] clr_mask, set_mask;

  assign cand = irr & ~imr & ~isr_q;

  // Scan from the channel just above L upward; the first hit is highest priority.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    top_valid = 1'b0;
    top_id    = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      scan_idx = low_q + ID_W'(i + 1);
      if (!win_valid && cand[scan_idx]) begin
        win_valid = 1'b1;
        win_id    = scan_idx;
      end
      if (!top_valid && isr_q[scan_idx]) begin
        top_valid = 1'b1;
        top_id    = scan_idx;
      end
    end
  end

  assign win_rank = win_id - low_q - ID_W'(1);
  assign top_rank = top_id - low_q - ID_W'(1);
  assign elig     = win_valid && (!top_valid || (win_rank < top_rank));

  always_comb begin
    clr_valid = 1'b0;
    clr_id    = '0;
    clr_mask  = '0;
    set_mask  = '0;
    if (specificEoi) begin
      if (isr_q[eoiLevel]) begin
        clr_valid = 1'b1;
        clr_id    = eoiLevel;
      end
    end else if (eoi && top_valid) begin
      clr_valid = 1'b1;
      clr_id    = top_id;
    end
    if (clr_valid) clr_mask[clr_id] = 1'b1;
    if (state_q == ASSERT && inta && elig) set_mask[win_id] = 1'b1;
    // Set is applied after clear so a same-bit collision keeps the bit.
    isr_d = (isr_q & ~clr_mask) | set_mask;
    low_d = low_q;
    if (setPriority)                        low_d = priorityLevel;
    else if (autoRotateMode && clr_valid)   low_d = clr_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      intReq_q <= 1'b0;
      vector_q <= '0;
      isr_q    <= '0;
      low_q    <= ID_W'(NUM_IRQ - 1);
    end else begin
      isr_q <= isr_d;
      low_q <= low_d;
      case (state_q)
        IDLE: begin
          if (elig) begin
            state_q  <= ASSERT;
            intReq_q <= 1'b1;
          end
        end
        ASSERT: begin
          if (inta) begin
            vector_q <= elig ? win_id : ID_W'(NUM_IRQ - 1);
            intReq_q <= 1'b0;
            state_q  <= ACK;
          end else if (!elig) begin
            intReq_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        ACK: begin
          intReq_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          intReq_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign intReq         = intReq_q;
  assign vector         = vector_q;
  assign isr            = isr_q;
  assign lowestPriority = low_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_interrupt_arbiter : directed scenarios plus randomized run against a model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_interrupt_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] irr = '0;
  logic [N-1:0] imr = '0;
  logic         autoRotateMode = 1'b0;
  logic         inta = 1'b0;
  logic         eoi = 1'b0;
  logic         specificEoi = 1'b0;
  logic [W-1:0] eoiLevel = '0;
  logic         setPriority = 1'b0;
  logic [W-1:0] priorityLevel = '0;
  logic         intReq;
  logic [W-1:0] vector;
  logic [N-1:0] isr;
  logic [W-1:0] lowestPriority;

  int cnt_cmp = 0;
  int cnt_err = 0;

  // Reference state: priorities are ranks computed by modular distance from L.
  bit [N-1:0] m_isr;
  int         m_L, m_vec, m_phase;
  bit         m_req;

  interrupt_arbiter #(.NUM_IRQ(N)) dut (
    .clk(clk), .reset(reset), .irr(irr), .imr(imr),
    .autoRotateMode(autoRotateMode), .inta(inta), .eoi(eoi),
    .specificEoi(specificEoi), .eoiLevel(eoiLevel),
    .setPriority(setPriority), .priorityLevel(priorityLevel),
    .intReq(intReq), .vector(vector), .isr(isr),
    .lowestPriority(lowestPriority)
  );

  always #5 clk = ~clk;

  function automatic int rnk(int c, int l);
    return (c - l - 1 + 2 * N) % N;
  endfunction

  // Advance model and DUT by one edge; inputs are sampled as currently driven.
  task automatic tick();
    bit [N-1:0] cand, nisr;
    int win, top, k, nL, nvec, nph;
    bit elig, nreq;
    cand = irr & ~imr & ~m_isr;
    win = -1; top = -1;
    for (int c = 0; c < N; c++) begin
      if (cand[c] && (win < 0 || rnk(c, m_L) < rnk(win, m_L))) win = c;
      if (m_isr[c] && (top < 0 || rnk(c, m_L) < rnk(top, m_L))) top = c;
    end
    elig = (win >= 0) && (top < 0 || rnk(win, m_L) < rnk(top, m_L));
    k = -1;
    if (specificEoi) begin
      if (m_isr[eoiLevel]) k = int'(eoiLevel);
    end else if (eoi) k = top;
    nisr = m_isr;
    if (k >= 0) nisr[k] = 1'b0;
    if (m_phase == 1 && inta && elig) nisr[win] = 1'b1;
    nL = setPriority ? int'(priorityLevel) : ((autoRotateMode && k >= 0) ? k : m_L);
    nvec = m_vec; nph = m_phase; nreq = m_req;
    if (m_phase == 0) begin
      if (elig) begin nph = 1; nreq = 1'b1; end
    end else if (m_phase == 1) begin
      if (inta) begin nvec = elig ? win : N - 1; nreq = 1'b0; nph = 2; end
      else if (!elig) begin nreq = 1'b0; nph = 0; end
    end else begin
      nph = 0; nreq = 1'b0;
    end
    if (reset) begin
      nisr = '0; nL = N - 1; nvec = 0; nph = 0; nreq = 1'b0;
    end
    @(posedge clk);
    m_isr = nisr; m_L = nL; m_vec = nvec; m_phase = nph; m_req = nreq;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    irr = '0; imr = '0;
    do_reset();
    cnt_cmp++; if (intReq !== 1'b0) begin cnt_err++; $display("FAIL reset_intReq: got %b exp 0", intReq); end
    cnt_cmp++; if (vector !== 3'd0) begin cnt_err++; $display("FAIL reset_vector: got %0d exp 0", vector); end
    cnt_cmp++; if (isr !== 8'h00) begin cnt_err++; $display("FAIL reset_isr: got %b exp 0", isr); end
    cnt_cmp++; if (lowestPriority !== 3'd7) begin cnt_err++; $display("FAIL reset_L: got %0d exp 7", lowestPriority); end
  endtask

  task automatic test_nested();
    irr = 8'b10001000; tick();
    cnt_cmp++; if (intReq !== 1'b1) begin cnt_err++; $display("FAIL nested_intReq: got %b exp 1", intReq); end
    inta = 1'b1; tick(); inta = 1'b0;
    cnt_cmp++; if (vector !== 3'd3) begin cnt_err++; $display("FAIL nested_vector: got %0d exp 3", vector); end
    cnt_cmp++; if (isr !== 8'b00001000) begin cnt_err++; $display("FAIL nested_isr: got %b exp 00001000", isr); end
    cnt_cmp++; if (intReq !== 1'b0) begin cnt_err++; $display("FAIL nested_ack_intReq: got %b exp 0", intReq); end
    tick();
  endtask

  task automatic test_preempt();
    irr = 8'b10000000; tick(); tick(); tick();
    cnt_cmp++; if (intReq !== 1'b0) begin cnt_err++; $display("FAIL block_intReq: got %b exp 0", intReq); end
    irr = 8'b10000010; tick();
    cnt_cmp++; if (intReq !== 1'b1) begin cnt_err++; $display("FAIL preempt_intReq: got %b exp 1", intReq); end
    inta = 1'b1; tick(); inta = 1'b0;
    cnt_cmp++; if (vector !== 3'd1) begin cnt_err++; $display("FAIL preempt_vector: got %0d exp 1", vector); end
    cnt_cmp++; if (isr !== 8'b00001010) begin cnt_err++; $display("FAIL preempt_isr: got %b exp 00001010", isr); end
    irr = '0; tick();
  endtask

  task automatic test_auto_rotate();
    irr = '0; do_reset();
    autoRotateMode = 1'b1; irr = 8'b00001000; tick();
    inta = 1'b1; tick(); inta = 1'b0; irr = '0; tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    cnt_cmp++; if (lowestPriority !== 3'd3) begin cnt_err++; $display("FAIL rotate_L: got %0d exp 3", lowestPriority); end
    cnt_cmp++; if (isr !== 8'h00) begin cnt_err++; $display("FAIL rotate_isr: got %b exp 0", isr); end
    irr = 8'b00000101; tick();
    inta = 1'b1; tick(); inta = 1'b0;
    cnt_cmp++; if (vector !== 3'd0) begin cnt_err++; $display("FAIL rotate_vector: got %0d exp 0", vector); end
    irr = '0; autoRotateMode = 1'b0; tick();
  endtask

  task automatic test_spurious();
    do_reset();
    irr = 8'b00100000; tick();
    cnt_cmp++; if (intReq !== 1'b1) begin cnt_err++; $display("FAIL spur_intReq: got %b exp 1", intReq); end
    irr = '0; inta = 1'b1; tick(); inta = 1'b0;
    cnt_cmp++; if (vector !== 3'd7) begin cnt_err++; $display("FAIL spur_vector: got %0d exp 7", vector); end
    cnt_cmp++; if (isr !== 8'h00) begin cnt_err++; $display("FAIL spur_isr: got %b exp 0", isr); end
    irr = 8'b00100000; inta = 1'b1; tick(); inta = 1'b0;
    cnt_cmp++; if (intReq !== 1'b0 || vector !== 3'd7) begin cnt_err++; $display("FAIL spur_ack_hold: got req %b vec %0d exp req 0 vec 7", intReq, vector); end
    tick();
    cnt_cmp++; if (intReq !== 1'b1) begin cnt_err++; $display("FAIL spur_reidle: got %b exp 1", intReq); end
    irr = '0; tick();
    cnt_cmp++; if (intReq !== 1'b0) begin cnt_err++; $display("FAIL vanish_intReq: got %b exp 0", intReq); end
  endtask

  task automatic test_specific_rotate();
    do_reset();
    setPriority = 1'b1; priorityLevel = 3'd4; tick(); setPriority = 1'b0;
    cnt_cmp++; if (lowestPriority !== 3'd4) begin cnt_err++; $display("FAIL setprio_L: got %0d exp 4", lowestPriority); end
    irr = 8'b00100001; tick();
    inta = 1'b1; tick(); inta = 1'b0;
    cnt_cmp++; if (vector !== 3'd5) begin cnt_err++; $display("FAIL setprio_vector: got %0d exp 5", vector); end
    irr = '0; tick();
    specificEoi = 1'b1; eoiLevel = 3'd2; eoi = 1'b1; tick();
    cnt_cmp++; if (isr !== 8'b00100000) begin cnt_err++; $display("FAIL seoi_noop_isr: got %b exp 00100000", isr); end
    eoiLevel = 3'd5; tick(); specificEoi = 1'b0; eoi = 1'b0;
    cnt_cmp++; if (isr !== 8'h00 || lowestPriority !== 3'd4) begin cnt_err++; $display("FAIL seoi_clear: got isr %b L %0d exp isr 0 L 4", isr, lowestPriority); end
  endtask

  task automatic test_reset_in_assert();
    do_reset();
    irr = 8'b00000100; tick();
    reset = 1'b1; inta = 1'b1; tick(); reset = 1'b0; inta = 1'b0;
    cnt_cmp++; if (intReq !== 1'b0 || isr !== 8'h00 || lowestPriority !== 3'd7 || vector !== 3'd0)
      begin cnt_err++; $display("FAIL reset_assert: got req %b isr %b L %0d vec %0d exp 0 0 7 0", intReq, isr, lowestPriority, vector); end
    irr = '0; tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) irr = N'($urandom);
      if ($urandom_range(15) == 0) imr = N'($urandom) & N'($urandom);
      if ($urandom_range(40) == 0) autoRotateMode = ~autoRotateMode;
      inta          = m_req ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
      eoi           = ($urandom_range(5) == 0);
      specificEoi   = ($urandom_range(7) == 0);
      eoiLevel      = W'($urandom);
      setPriority   = ($urandom_range(19) == 0);
      priorityLevel = W'($urandom);
      reset         = ($urandom_range(199) == 0);
      tick();
      cnt_cmp++;
      if ({intReq, vector, isr, lowestPriority} !== {m_req, W'(m_vec), m_isr, W'(m_L)}) begin
        cnt_err++;
        $display("FAIL random[%0d]: got req %b vec %0d isr %b L %0d exp req %b vec %0d isr %b L %0d",
                 n, intReq, vector, isr, lowestPriority, m_req, m_vec, m_isr, m_L);
      end
    end
    reset = 1'b0; inta = 1'b0; eoi = 1'b0; specificEoi = 1'b0; setPriority = 1'b0;
  endtask

  initial begin
    m_isr = '0; m_L = N - 1; m_vec = 0; m_phase = 0; m_req = 1'b0;
    #2;
    test_reset();
    test_nested();
    test_preempt();
    test_auto_rotate();
    test_spurious();
    test_specific_rotate();
    test_reset_in_assert();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
    $finish;
  end

endmodule
`default_nettype wire
